// File: rtl/em4100_tag_scheduler_pkg.sv
// Shared types and constants for the EM4100 tag scheduler.
package em4100_tag_scheduler_pkg;

   localparam int unsigned EM4100_FRAME_CYCLES = 74;
   localparam int unsigned EM4100_ID_W         = 40;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_t;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/em4100_tag_scheduler_if.sv
// Host/config bus and encoder drive signals of the tag scheduler.
interface em4100_tag_scheduler_if
   import em4100_tag_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4
);
   localparam int unsigned IW = idx_w(NUM_SLOTS);

   logic                   run;
   logic [NUM_SLOTS-1:0]   slot_en;
   logic                   wr_en;
   logic [IW-1:0]          wr_idx;
   logic [EM4100_ID_W-1:0] wr_data;
   logic                   enc_tx;
   logic [EM4100_ID_W-1:0] enc_data;
   logic                   busy;
   logic [IW-1:0]          cur_slot;
   logic                   frame_done;

   modport master (
      output run, slot_en, wr_en, wr_idx, wr_data,
      input  enc_tx, enc_data, busy, cur_slot, frame_done
   );

   modport slave (
      input  run, slot_en, wr_en, wr_idx, wr_data,
      output enc_tx, enc_data, busy, cur_slot, frame_done
   );

endinterface

// File: rtl/em4100_rr_pick.sv
// Combinational round-robin pick: first enabled slot after last, wrapping.
module em4100_rr_pick
   import em4100_tag_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4
) (
   input  logic [NUM_SLOTS-1:0]        mask,
   input  logic [idx_w(NUM_SLOTS)-1:0] last,
   output logic [idx_w(NUM_SLOTS)-1:0] grant,
   output logic                        valid
);
   localparam int unsigned IW = idx_w(NUM_SLOTS);

   int unsigned   k;
   logic [IW-1:0] cand;

   // Scan last+1 .. last+NUM_SLOTS; last itself comes up last so a lone slot re-wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      k     = '0;
      cand  = '0;
      for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
         k    = (32'(last) + i) % NUM_SLOTS;
         cand = IW'(k);
         if (!valid && mask[cand]) begin
            valid = 1'b1;
            grant = cand;
         end
      end
   end

endmodule

// File: rtl/em4100_tag_scheduler.sv
// Time-shares one EM4100 encoder between NUM_SLOTS stored tag IDs.
module em4100_tag_scheduler
   import em4100_tag_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SLOTS    = 4,
   parameter int unsigned REPEATS      = 8,
   parameter int unsigned FRAME_CYCLES = EM4100_FRAME_CYCLES,
   parameter int unsigned GAP_CYCLES   = 2
) (
   input logic                   clk,
   input logic                   rst,
   em4100_tag_scheduler_if.slave bus
);
   localparam int unsigned IW = idx_w(NUM_SLOTS);
   localparam int unsigned CW = idx_w(FRAME_CYCLES);
   localparam int unsigned RW = $clog2(REPEATS + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   logic [EM4100_ID_W-1:0] ids [NUM_SLOTS];
   state_t                 state;
   logic [IW-1:0]          last;
   logic [IW-1:0]          grant;
   logic                   grant_valid;
   logic [CW-1:0]          cnt;
   logic [RW-1:0]          rep;
   logic [GW-1:0]          gap;

   em4100_rr_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick (
      .mask  (bus.slot_en),
      .last  (last),
      .grant (grant),
      .valid (grant_valid)
   );

   // ID table: host writes land immediately; picks read the pre-write value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) ids[i] <= '0;
      end else if (bus.wr_en) begin
         ids[bus.wr_idx] <= bus.wr_data;
      end
   end

   // Scheduler FSM with registered encoder drive and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bus.enc_tx     <= 1'b0;
         bus.enc_data   <= '0;
         bus.busy       <= 1'b0;
         bus.cur_slot   <= '0;
         bus.frame_done <= 1'b0;
         last           <= IW'(NUM_SLOTS - 1);
         cnt            <= '0;
         rep            <= '0;
         gap            <= '0;
      end else begin
         bus.frame_done <= 1'b0;
         case (state)
            IDLE: begin
               bus.enc_tx <= 1'b0;
               bus.busy   <= 1'b0;
               if (bus.run && grant_valid) begin
                  bus.cur_slot <= grant;
                  bus.enc_data <= ids[grant];
                  bus.busy     <= 1'b1;
                  last         <= grant;
                  gap          <= '0;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               bus.enc_tx <= 1'b0;
               bus.busy   <= 1'b1;
               if (gap == GW'(GAP_CYCLES - 1)) begin
                  bus.enc_tx <= 1'b1;
                  cnt        <= '0;
                  rep        <= '0;
                  state      <= SEND;
               end else begin
                  gap <= gap + GW'(1);
               end
            end
            SEND: begin
               // frame_done is raised one cycle early so the registered pulse lands on cnt=FRAME_CYCLES-1.
               if (cnt == CW'(FRAME_CYCLES - 1)) begin
                  cnt <= '0;
                  rep <= rep + RW'(1);
                  if (!bus.run) begin
                     bus.enc_tx <= 1'b0;
                     bus.busy   <= 1'b0;
                     state      <= IDLE;
                  end else if (rep == RW'(REPEATS - 1)) begin
                     bus.enc_tx <= 1'b0;
                     if (grant_valid) begin
                        bus.cur_slot <= grant;
                        bus.enc_data <= ids[grant];
                        last         <= grant;
                        gap          <= '0;
                        state        <= LOAD;
                     end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                     end
                  end
               end else begin
                  cnt            <= cnt + CW'(1);
                  bus.frame_done <= (cnt == CW'(FRAME_CYCLES - 2));
               end
            end
            default: begin
               bus.enc_tx <= 1'b0;
               bus.busy   <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_em4100_tag_scheduler.sv
// Self-checking bench: cycle model of the scheduling rules plus directed visit measurements.
module tb_em4100_tag_scheduler;
   localparam int NS  = 4;
   localparam int REP = 2;
   localparam int FC  = 74;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   em4100_tag_scheduler_if #(.NUM_SLOTS(NS)) bus ();

   em4100_tag_scheduler #(
      .NUM_SLOTS    (NS),
      .REPEATS      (REP),
      .FRAME_CYCLES (FC),
      .GAP_CYCLES   (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 gap before a visit, 2 transmitting
   int          m_mode, m_gap_left, m_pos, m_frames, m_last, m_slot;
   logic        m_tx, m_busy, m_fd;
   logic [39:0] m_data;
   logic [39:0] m_ids [NS];
   bit          cmp_on = 0;

   function automatic int next_slot(input logic [NS-1:0] en, input int last);
      for (int i = 1; i <= NS; i++) begin
         int s;
         s = (last + i) % NS;
         if (en[s]) return s;
      end
      return -1;
   endfunction

   task automatic m_take(input int s);
      m_slot = s; m_last = s; m_data = m_ids[s];
      m_mode = 1; m_gap_left = GAP; m_busy = 1; m_tx = 0;
   endtask

   task automatic m_idle();
      m_mode = 0; m_tx = 0; m_busy = 0;
   endtask

   task automatic model_step();
      int s;
      if (rst) begin
         m_mode = 0; m_tx = 0; m_busy = 0; m_fd = 0; m_data = '0; m_slot = 0;
         m_last = NS - 1; m_pos = 0; m_frames = 0; m_gap_left = 0;
         for (int i = 0; i < NS; i++) m_ids[i] = '0;
      end else begin
         m_fd = 0;
         case (m_mode)
            0: begin
               m_tx = 0; m_busy = 0;
               if (bus.run) begin
                  s = next_slot(bus.slot_en, m_last);
                  if (s >= 0) m_take(s);
               end
            end
            1: begin
               m_gap_left--;
               if (m_gap_left == 0) begin
                  m_mode = 2; m_tx = 1; m_pos = 0; m_frames = 0;
               end
            end
            default: begin
               if (m_pos == FC - 1) begin
                  m_pos = 0; m_frames++;
                  if (!bus.run) m_idle();
                  else if (m_frames == REP) begin
                     s = next_slot(bus.slot_en, m_last);
                     if (s >= 0) m_take(s); else m_idle();
                  end
               end else begin
                  m_pos++;
                  m_fd = (m_pos == FC - 1);
               end
            end
         endcase
         if (bus.wr_en) m_ids[bus.wr_idx] = bus.wr_data;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         if (rst) cmp_on = 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            chk("enc_tx",     64'(bus.enc_tx),     64'(m_tx));
            chk("enc_data",   64'(bus.enc_data),   64'(m_data));
            chk("busy",       64'(bus.busy),       64'(m_busy));
            chk("cur_slot",   64'(bus.cur_slot),   64'(m_slot));
            chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic write_id(input int idx, input logic [39:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_idx = 2'(idx); bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // Measures one slot visit: gap length, tx-high length, frame_done positions.
   // act at tx-high cycle act_at: 1 clear slot0 enable, 2 clear all, 3 drop run, 4 write all-ones to current slot.
   task automatic visit(input int act_at, input int act,
                        output int gap, output int hi, output int fd1, output int fd2,
                        output int slot, output logic [39:0] d0, output logic [39:0] dend);
      int budget;
      budget = 1000;
      gap = 0; hi = 0; fd1 = -1; fd2 = -1; slot = -1; d0 = '0; dend = '0;
      while (!(bus.busy && !bus.enc_tx) && budget > 0) begin @(negedge clk); budget--; end
      slot = int'(bus.cur_slot);
      d0   = bus.enc_data;
      while (bus.busy && !bus.enc_tx && budget > 0) begin gap++; @(negedge clk); budget--; end
      while (bus.enc_tx && budget > 0) begin
         hi++;
         if (bus.frame_done) begin
            if (fd1 < 0) fd1 = hi; else fd2 = hi;
         end
         if (hi == act_at) begin
            case (act)
               1: bus.slot_en = bus.slot_en & 4'b1110;
               2: bus.slot_en = 4'b0000;
               3: bus.run = 1'b0;
               4: begin bus.wr_en = 1'b1; bus.wr_idx = bus.cur_slot; bus.wr_data = '1; end
               default: ;
            endcase
         end
         if (act == 4 && hi == act_at + 1) bus.wr_en = 1'b0;
         dend = bus.enc_data;
         @(negedge clk);
         budget--;
      end
      if (budget <= 0) begin
         checks++; failures++;
         $display("FAIL visit_timeout actual=budget_exhausted required=visit_end at %0t", $time);
      end
   endtask

   int          g, h, f1, f2, sl;
   logic [39:0] d0, de;
   logic [39:0] rr_ids [NS];
   int          rr_order [4];

   initial begin
      bus.run = 1'b0; bus.slot_en = '0; bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
      rr_ids[0] = 40'hA0A0A0A0A0; rr_ids[1] = 40'hB1B1B1B1B1;
      rr_ids[2] = 40'hC2C2C2C2C2; rr_ids[3] = 40'hD3D3D3D3D3;
      rr_order[0] = 0; rr_order[1] = 2; rr_order[2] = 3; rr_order[3] = 0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_enc_tx",     64'(bus.enc_tx), 64'd0);
      chk("rst_enc_data",   64'(bus.enc_data), 64'd0);
      chk("rst_busy",       64'(bus.busy), 64'd0);
      chk("rst_cur_slot",   64'(bus.cur_slot), 64'd0);
      chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
      rst = 1'b0;

      // single slot, two frames per visit
      write_id(0, 40'h123456789A);
      bus.slot_en = 4'b0001; bus.run = 1'b1;
      visit(0, 0, g, h, f1, f2, sl, d0, de);
      chk("single_gap",  64'(g), 64'd2);
      chk("single_hi",   64'(h), 64'd148);
      chk("single_fd1",  64'(f1), 64'd74);
      chk("single_fd2",  64'(f2), 64'd148);
      chk("single_slot", 64'(sl), 64'd0);
      chk("single_data", 64'(d0), 64'h123456789A);
      visit(0, 0, g, h, f1, f2, sl, d0, de);
      chk("single_regap", 64'(g), 64'd2);
      chk("single_reslot", 64'(sl), 64'd0);

      // reset mid-SEND
      repeat (10) @(negedge clk);
      chk("pre_rst_tx", 64'(bus.enc_tx), 64'd1);
      rst = 1'b1; bus.run = 1'b0; bus.slot_en = '0;
      @(negedge clk);
      chk("midrst_tx",    64'(bus.enc_tx), 64'd0);
      chk("midrst_busy",  64'(bus.busy), 64'd0);
      chk("midrst_fd",    64'(bus.frame_done), 64'd0);
      chk("midrst_slot",  64'(bus.cur_slot), 64'd0);
      chk("midrst_data",  64'(bus.enc_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // round robin over slots 0,2,3
      for (int i = 0; i < NS; i++) write_id(i, rr_ids[i]);
      bus.slot_en = 4'b1101; bus.run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         visit(0, 0, g, h, f1, f2, sl, d0, de);
         chk("rr_slot", 64'(sl), 64'(rr_order[i]));
         chk("rr_data", 64'(d0), 64'(rr_ids[rr_order[i]]));
         chk("rr_gap",  64'(g), 64'd2);
         chk("rr_hi",   64'(h), 64'd148);
      end

      // live write to the slot being sent
      visit(30, 4, g, h, f1, f2, sl, d0, de);
      chk("live_slot",     64'(sl), 64'd2);
      chk("live_data_end", 64'(de), 64'hC2C2C2C2C2);
      visit(0, 0, g, h, f1, f2, sl, d0, de);
      chk("live_next3", 64'(sl), 64'd3);
      visit(0, 0, g, h, f1, f2, sl, d0, de);
      chk("live_next0", 64'(sl), 64'd0);
      visit(0, 0, g, h, f1, f2, sl, d0, de);
      chk("live_revisit_slot", 64'(sl), 64'd2);
      chk("live_revisit_data", 64'(d0), 64'hFFFFFFFFFF);

      // graceful stop: run drops at frame cycle 10
      visit(11, 3, g, h, f1, f2, sl, d0, de);
      chk("stop_slot", 64'(sl), 64'd3);
      chk("stop_hi",   64'(h), 64'd74);
      chk("stop_fd1",  64'(f1), 64'd74);
      chk("stop_fd2",  64'(f2), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("stop_busy", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("stop_idle_tx", 64'(bus.enc_tx), 64'd0);

      // enable drop mid-frame, then mask to zero
      bus.slot_en = 4'b0011; bus.run = 1'b1;
      visit(20, 1, g, h, f1, f2, sl, d0, de);
      chk("endrop_slot", 64'(sl), 64'd0);
      chk("endrop_hi",   64'(h), 64'd148);
      visit(50, 2, g, h, f1, f2, sl, d0, de);
      chk("endrop_next_slot", 64'(sl), 64'd1);
      chk("endrop_next_data", 64'(d0), 64'hB1B1B1B1B1);
      chk("endrop_next_hi",   64'(h), 64'd148);
      chk("mask0_busy", 64'(bus.busy), 64'd0);
      repeat (5) @(negedge clk);
      chk("mask0_idle_tx",   64'(bus.enc_tx), 64'd0);
      chk("mask0_idle_busy", 64'(bus.busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
